// File: rtl/dff.sv
// dff: parameterised register pipeline with synchronous active-high reset.
//   Parameters
//     WIDTH       - data width of d and q (>= 1)
//     RESET_VALUE - value every stage takes on a reset edge
//     STAGES      - number of register stages between d and q (1..8)
//   Ports
//     clk   - rising-edge clock
//     reset - synchronous, active-high reset (wins over d)
//     d     - data in, sampled only at rising edges of clk
//     q     - data out, driven straight from the last stage
//   Optional macro DFF_XCHECK_EN compiles in simulation-only X/Z checks
//   on reset and d; register behaviour is identical either way.
module dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > 8) begin : g_bad_param
      $error("dff: illegal parameters WIDTH=%0d STAGES=%0d (need WIDTH>=1, 1<=STAGES<=8)",
             WIDTH, STAGES);
    end
  endgenerate

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  // stage[0] takes d, every later stage takes its predecessor.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  // Reset loads every stage so in-flight data is discarded in one edge.
  always_ff @(posedge clk) begin
    if (reset) stage_q <= {STAGES{RESET_VALUE}};
    else       stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

`ifdef DFF_XCHECK_EN
  // Simulation-only: flag unknown control or unknown data being captured.
  always @(posedge clk) begin
    if ($isunknown(reset))
      $error("dff: reset is X/Z at rising edge");
    else if (!reset && $isunknown(d))
      $error("dff: d is X/Z at rising edge with reset=0");
  end
`else
`endif

endmodule

// File: tb/tb_dff.sv
module tb_dff;
  logic       clk = 1'b0;
  logic       rst1, d1, q1;
  logic       r3;
  logic [7:0] d3, q3;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  dff u_d1 (.clk(clk), .reset(rst1), .d(d1), .q(q1));

  dff #(.WIDTH(8), .RESET_VALUE(8'hA5), .STAGES(3)) u_d3
    (.clk(clk), .reset(r3), .d(d3), .q(q3));

  typedef struct {
    logic r;
    logic d;
    logic q;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b0};  // reset with d=1 -> 0
    vt[1]  = '{1'b1, 1'b1, 1'b0};  // still in reset
    vt[2]  = '{1'b0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b0};  // reset beats d
    vt[10] = '{1'b0, 1'b1, 1'b1};

    rst1 = 1'b1; d1 = 1'b1; r3 = 1'b1; d3 = 8'h3C;
    #1;

    for (int i = 0; i < 11; i++) begin
      rst1 = vt[i].r; d1 = vt[i].d;
      tick();
      chk($sformatf("vec%0d", i), {7'b0, q1}, {7'b0, vt[i].q});
    end

    // Release reset with d=1: q stays 0 until the next edge.
    rst1 = 1'b1; d1 = 1'b1; tick();
    chk("rst_again", {7'b0, q1}, 8'h00);
    rst1 = 1'b0; #2;
    chk("pre_edge_hold", {7'b0, q1}, 8'h00);
    tick();
    chk("first_capture", {7'b0, q1}, 8'h01);

    // Mid-cycle d pulses must not reach q.
    d1 = 1'b1; #2 d1 = 1'b0; #2 d1 = 1'b1; tick();
    chk("glitch_low", {7'b0, q1}, 8'h01);
    d1 = 1'b0; tick();
    chk("d_zero", {7'b0, q1}, 8'h00);
    #2 d1 = 1'b1; #2 d1 = 1'b0; tick();
    chk("glitch_high", {7'b0, q1}, 8'h00);

    // Reset raised between edges acts only at the next edge.
    d1 = 1'b1; tick();
    chk("q_one", {7'b0, q1}, 8'h01);
    #3 rst1 = 1'b1; #1;
    chk("rst_no_async", {7'b0, q1}, 8'h01);
    tick();
    chk("rst_edge", {7'b0, q1}, 8'h00);
    rst1 = 1'b0; d1 = 1'b1; tick();
    chk("rst_drop", {7'b0, q1}, 8'h01);
    #2 rst1 = 1'b1; #2 rst1 = 1'b0; tick();
    chk("rst_pulse_ignored", {7'b0, q1}, 8'h01);

    // Unknown d under reset still yields the reset value.
    rst1 = 1'b1; d1 = 1'bx; tick();
    chk("x_d_in_reset", {7'b0, q1}, 8'h00);
    rst1 = 1'b0; d1 = 1'b0; tick();
    chk("after_x", {7'b0, q1}, 8'h00);

    // Three-stage, 8-bit pipeline with RESET_VALUE A5.
    r3 = 1'b1; d3 = 8'h3C; tick();
    chk("p3_rst", q3, 8'hA5);
    r3 = 1'b0; tick();
    chk("p3_lat1", q3, 8'hA5);
    tick();
    chk("p3_lat2", q3, 8'hA5);
    tick();
    chk("p3_lat3", q3, 8'h3C);
    tick();
    chk("p3_hold", q3, 8'h3C);
    r3 = 1'b1; tick();
    chk("p3_rst_again", q3, 8'hA5);
    r3 = 1'b0; d3 = 8'h11; tick();
    chk("p3_s1", q3, 8'hA5);
    d3 = 8'h22; tick();
    chk("p3_s2", q3, 8'hA5);
    d3 = 8'h33; tick();
    chk("p3_s3", q3, 8'h11);
    d3 = 8'h44; tick();
    chk("p3_s4", q3, 8'h22);
    r3 = 1'b1; tick();
    chk("p3_flush", q3, 8'hA5);
    r3 = 1'b0; d3 = 8'h55; tick();
    chk("p3_f1", q3, 8'hA5);
    d3 = 8'h66; tick();
    chk("p3_f2", q3, 8'hA5);
    tick();
    chk("p3_f3", q3, 8'h55);
    tick();
    chk("p3_f4", q3, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 The block SHALL expose exactly these parameters:
- WIDTH, default 1, bit width of d and q.
- RESET_VALUE, default all-zeros (WIDTH bits), value loaded into every stage by reset.
- STAGES, default 1, number of register stages between d and q.

REQ-002 The block SHALL have these ports, listed in declaration order, which is also the positional-connection order:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- d  input  WIDTH  data in.
- q  output  WIDTH  data out, driven directly by the final register stage.

REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

REQ-004 With default parameters the block SHALL behave as a single-bit D flip-flop with synchronous active-high reset.

Function
REQ-005 The block SHALL contain STAGES registers of WIDTH bits, stage[0] through stage[STAGES-1], all updated only on the rising edge of clk.

REQ-006 At each rising edge with reset=0, stage[0] SHALL load d and stage[i] SHALL load stage[i-1] for i>=1.

REQ-007 q SHALL equal stage[STAGES-1] with no combinational path from d to q.

REQ-008 Latency SHALL be exactly STAGES rising edges: a value on d at edge N appears on q just after edge N+STAGES-1.

REQ-009 Changes on d between rising edges, including glitches, SHALL have no effect on q.

REQ-010 Elaboration SHALL fail with a message if WIDTH<1, STAGES<1 or STAGES>8.

Reset
REQ-011 At a rising edge with reset=1, every stage SHALL load RESET_VALUE, so q=RESET_VALUE just after that edge.

REQ-012 Reset SHALL take priority over d at the same edge.

REQ-013 Reset asserted or deasserted between edges SHALL have no effect until the next rising edge (no asynchronous path).

REQ-014 Reset asserted mid-operation SHALL discard all in-flight data; nothing captured before that edge SHALL reach q afterwards.

REQ-015 At the first edge with reset=0 after reset, stage[0] SHALL capture d; q SHALL remain RESET_VALUE for the following STAGES-1 edges.

REQ-016 Before the first reset edge, the state of q is undefined. The RTL SHALL NOT rely on initial blocks for functional reset.

Configuration
REQ-017 Macro DFF_XCHECK_EN SHALL compile in or out simulation-only X/Z checks.

REQ-018 With DFF_XCHECK_EN defined, the block SHALL report an error message at any rising edge where reset is X/Z. It SHALL also report an error where reset=0 and any bit of d is X/Z. Register behaviour SHALL be unchanged.

REQ-019 Without DFF_XCHECK_EN, no check code SHALL be compiled, and the synthesized logic SHALL be identical in both cases.

Verification
REQ-020 Default parameters, 10 ns clock. Hold reset=1 and d=1 for 2 edges -> q=0 after the first such edge and stays 0.

REQ-021 Default parameters. Deassert reset with d=1 -> q=0 until the next rising edge, then q=1.

REQ-022 Default parameters, reset=0. Apply d=1,0,1 on consecutive cycles -> q=1,0,1, each one edge later; a mid-cycle d pulse does not appear on q.

REQ-023 Default parameters, q=1. Raise reset between edges -> q stays 1 until the next edge, then q=0. Drop reset with d=1 -> q=1 after the following edge.

REQ-024 WIDTH=8, STAGES=3, RESET_VALUE=8'hA5. Reset, then d=8'h3C held -> q=8'hA5 for 2 edges after reset release, q=8'h3C after the 3rd edge. Reasserting reset at any point -> q=8'hA5 at the next edge.

REQ-025 DFF_XCHECK_EN defined. Drive d=X with reset=0 -> error reported at the edge. Drive d=X with reset=1 -> no error, q=RESET_VALUE.
